gemm_ctrl: RTL

- Sequencer for the custom GEMM systolic array attached to the main_pipe RISC-V core.
- The CPU programs it through a small memory-mapped register file. It fetches packed int8 A columns and B rows from data memory, feeds the array, drains the skew, and writes the SA_DIM x SA_DIM int32 result tile back to memory.
- It raises busy while running and an irq pulse on completion.

---
 rtl/gemm_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/gemm_ctrl.sv
// Sequencer for the GEMM systolic array: MMIO register file, operand fetch,
// feed/flush sequencing and result write-back over a single-outstanding memory port.
module gemm_ctrl #(
  parameter int SA_DIM = 4,
  parameter int KMAX_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [31:0]           cfg_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  sa_clr,
  output logic                  sa_feed,
  output logic [8*SA_DIM-1:0]   sa_a,
  output logic [8*SA_DIM-1:0]   sa_b,
  output logic [3:0]            sa_res_sel,
  input  logic [31:0]           sa_res_data,
  output logic                  busy,
  output logic                  irq
);

  if (SA_DIM != 4) begin : g_dim_check
    $error("gemm_ctrl: only SA_DIM=4 is supported");
  end

  localparam int FLUSH_LEN = 2 * SA_DIM - 1;
  localparam int N_RES     = SA_DIM * SA_DIM;
  localparam int FL_W      = $clog2(FLUSH_LEN);
  localparam int J_W       = $clog2(N_RES);

  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LEN - 1);
  localparam logic [J_W-1:0]  J_LAST  = J_W'(N_RES - 1);

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_A_BASE = 5'h08;
  localparam logic [4:0] ADDR_B_BASE = 5'h0C;
  localparam logic [4:0] ADDR_C_BASE = 5'h10;
  localparam logic [4:0] ADDR_K      = 5'h14;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_RDA,
    S_WTA,
    S_RDB,
    S_WTB,
    S_FEED,
    S_FLUSH,
    S_WR,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]         a_base_q, b_base_q, c_base_q;
  logic [KMAX_W-1:0]   k_cfg_q;
  logic                done_q, err_q;

  logic [KMAX_W-1:0]   k_q;
  logic [FL_W-1:0]     fl_q;
  logic [J_W-1:0]      j_q;
  logic [8*SA_DIM-1:0] a_hold_q, b_hold_q;

  logic                idle;
  logic                wr_ctrl, wr_status, cfg_wr_ok;
  logic                start_ok, start_err;
  logic [KMAX_W-1:0]   k_inc;
  logic [31:0]         k_off, j_off;

  assign idle      = (state_q == S_IDLE);
  assign busy      = !idle;
  assign wr_ctrl   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign wr_status = cfg_we && (cfg_addr == ADDR_STATUS);
  assign cfg_wr_ok = cfg_we && idle;

  // A start while running is dropped silently; only an idle start with K=0 flags err.
  assign start_ok  = wr_ctrl && cfg_wdata[0] && idle && (k_cfg_q != '0);
  assign start_err = wr_ctrl && cfg_wdata[0] && idle && (k_cfg_q == '0);

  assign k_inc = k_q + 1'b1;
  assign k_off = {{(30-KMAX_W){1'b0}}, k_q, 2'b00};
  assign j_off = {{(30-J_W){1'b0}}, j_q, 2'b00};

  // Register file and sticky status bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      k_cfg_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop updates from pre-edge values.
      if (cfg_wr_ok && (cfg_addr == ADDR_A_BASE)) a_base_q <= {cfg_wdata[31:2], 2'b00};
      if (cfg_wr_ok && (cfg_addr == ADDR_B_BASE)) b_base_q <= {cfg_wdata[31:2], 2'b00};
      if (cfg_wr_ok && (cfg_addr == ADDR_C_BASE)) c_base_q <= {cfg_wdata[31:2], 2'b00};
      if (cfg_wr_ok && (cfg_addr == ADDR_K))      k_cfg_q  <= cfg_wdata[KMAX_W-1:0];

      if (start_ok || (wr_status && cfg_wdata[1])) done_q <= 1'b0;
      if (state_q == S_DONE)                       done_q <= 1'b1;

      if (wr_status && cfg_wdata[2]) err_q <= 1'b0;
      if (start_err)                 err_q <= 1'b1;
    end
  end

  // Loop counters and operand holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q      <= '0;
      fl_q     <= '0;
      j_q      <= '0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (state_q == S_CLR) begin
        k_q  <= '0;
        fl_q <= '0;
      end
      if (state_q == S_FEED) k_q <= k_inc;
      if (state_q == S_FLUSH) begin
        fl_q <= fl_q + 1'b1;
        j_q  <= '0;
      end
      if ((state_q == S_WR) && mem_gnt) j_q <= j_q + 1'b1;
      if ((state_q == S_WTA) && mem_rvalid) a_hold_q <= mem_rdata[8*SA_DIM-1:0];
      if ((state_q == S_WTB) && mem_rvalid) b_hold_q <= mem_rdata[8*SA_DIM-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_CLR;
      S_CLR:   state_d = S_RDA;
      S_RDA:   if (mem_gnt) state_d = S_WTA;
      S_WTA:   if (mem_rvalid) state_d = S_RDB;
      S_RDB:   if (mem_gnt) state_d = S_WTB;
      S_WTB:   if (mem_rvalid) state_d = S_FEED;
      S_FEED:  state_d = (k_inc == k_cfg_q) ? S_FLUSH : S_RDA;
      S_FLUSH: if (fl_q == FL_LAST) state_d = S_WR;
      S_WR:    if (mem_gnt && (j_q == J_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Requests are decoded purely from state so a reset drops them immediately.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    sa_clr     = 1'b0;
    sa_feed    = 1'b0;
    sa_a       = '0;
    sa_b       = '0;
    sa_res_sel = '0;
    irq        = 1'b0;
    unique case (state_q)
      S_CLR: sa_clr = 1'b1;
      S_RDA: begin
        mem_req  = 1'b1;
        mem_addr = a_base_q + k_off;
      end
      S_RDB: begin
        mem_req  = 1'b1;
        mem_addr = b_base_q + k_off;
      end
      S_FEED: begin
        sa_feed = 1'b1;
        sa_a    = a_hold_q;
        sa_b    = b_hold_q;
      end
      S_FLUSH: sa_feed = 1'b1;
      S_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = c_base_q + j_off;
        mem_wdata  = sa_res_data;
        sa_res_sel = j_q;
      end
      S_DONE: irq = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_STATUS: cfg_rdata = {29'd0, err_q, done_q, busy};
      ADDR_A_BASE: cfg_rdata = a_base_q;
      ADDR_B_BASE: cfg_rdata = b_base_q;
      ADDR_C_BASE: cfg_rdata = c_base_q;
      ADDR_K:      cfg_rdata = {{(32-KMAX_W){1'b0}}, k_cfg_q};
      default:     cfg_rdata = '0;
    endcase
  end

endmodule
